// File: rtl/mem_router_pkg.sv
// Shared types and constants for the CPU-side memory router and the region decoder.
package mem_router_pkg;

    localparam int unsigned REGION_W = 4;

    localparam int unsigned ERR_UNMAPPED = 0;
    localparam int unsigned ERR_RO       = 1;
    localparam int unsigned ERR_TMO      = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_region_decode.sv
// Combinational priority decoder: address nibble -> channel hit, channel index, read-only flag.
module mem_region_decode
    import mem_router_pkg::*;
#(
    parameter int unsigned            NCH        = 2,
    parameter logic [16*NCH-1:0]      REGION_MAP = {16'h9000, 16'h6FFF},
    parameter logic [NCH-1:0]         RO_MASK    = 2'b10,
    localparam int unsigned           SEL_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [REGION_W-1:0] nibble,
    output logic                hit,
    output logic [SEL_W-1:0]    sel,
    output logic                ro
);

    // Ascending scan that keeps the first match, so the lowest channel index wins overlaps.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        ro  = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!hit && REGION_MAP[16*i + 32'(nibble)]) begin
                hit = 1'b1;
                sel = SEL_W'(i);
                ro  = RO_MASK[i];
            end
        end
    end

endmodule

// File: rtl/mem_region_router.sv
// CPU memory front end: decodes addr[19:16] to a downstream channel and runs a
// registered request/acknowledge handshake with protection, default data and timeout.
module mem_region_router
    import mem_router_pkg::*;
#(
    parameter int unsigned       NCH        = 2,
    parameter logic [16*NCH-1:0] REGION_MAP = {16'h9000, 16'h6FFF},
    parameter logic [NCH-1:0]    RO_MASK    = 2'b10,
    parameter int unsigned       TIMEOUT    = 255,
    parameter logic [15:0]       DEF_DATA   = 16'h0000
) (
    input  logic                cpu_clk,
    input  logic                reset,
    input  logic [19:0]         addr,
    input  logic [15:0]         wr_data,
    input  logic                we,
    input  logic                byte_m,
    input  logic                mem_op,
    output logic [15:0]         rd_data,
    output logic                ready,
    output logic [2:0]          err,
    output logic [NCH-1:0]      ch_en,
    output logic [19:0]         ch_addr,
    output logic [15:0]         ch_wr_data,
    output logic                ch_we,
    output logic                ch_byte_m,
    input  logic [16*NCH-1:0]   ch_rd_data,
    input  logic [NCH-1:0]      ch_ready
);

    localparam int unsigned SEL_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic [SEL_W-1:0]   sel_q;

    logic               dec_hit;
    logic [SEL_W-1:0]   dec_sel;
    logic               dec_ro;

    mem_region_decode #(
        .NCH        (NCH),
        .REGION_MAP (REGION_MAP),
        .RO_MASK    (RO_MASK)
    ) u_decode (
        .nibble (addr[19:16]),
        .hit    (dec_hit),
        .sel    (dec_sel),
        .ro     (dec_ro)
    );

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state      <= IDLE;
            ready      <= 1'b0;
            err        <= '0;
            ch_en      <= '0;
            rd_data    <= '0;
            ch_addr    <= '0;
            ch_wr_data <= '0;
            ch_we      <= 1'b0;
            ch_byte_m  <= 1'b0;
            timer      <= '0;
            sel_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        ch_addr    <= addr;
                        ch_wr_data <= wr_data;
                        ch_we      <= we;
                        ch_byte_m  <= byte_m;
                        timer      <= '0;
                        sel_q      <= dec_sel;
                        if (!dec_hit) begin
                            state   <= DONE;
                            ready   <= 1'b1;
                            rd_data <= DEF_DATA;
                            err     <= 3'(1 << ERR_UNMAPPED);
                        end else if (we && dec_ro) begin
                            state   <= DONE;
                            ready   <= 1'b1;
                            rd_data <= DEF_DATA;
                            err     <= 3'(1 << ERR_RO);
                        end else begin
                            state <= REQ;
                            ch_en <= NCH'(1) << dec_sel;
                            err   <= '0;
                        end
                    end
                end
                REQ: begin
                    if (ch_ready[sel_q]) begin
                        if (!ch_we)
                            rd_data <= ch_rd_data[16*sel_q +: 16];
                        ch_en <= '0;
                        err   <= '0;
                        ready <= 1'b1;
                        state <= DONE;
                    end else if (timer == TMR_LAST) begin
                        ch_en   <= '0;
                        rd_data <= DEF_DATA;
                        err     <= 3'(1 << ERR_TMO);
                        ready   <= 1'b1;
                        state   <= DONE;
                    end else if (timer != TMR_MAX) begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    if (!mem_op) begin
                        ready <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_region_router.sv
// Directed bench for mem_region_router: map with nibble 0xA unmapped, 0xB overlapping, TIMEOUT=8.
module tb_mem_region_router;
    import mem_router_pkg::*;

    logic        cpu_clk = 1'b0;
    logic        reset;
    logic [19:0] addr;
    logic [15:0] wr_data;
    logic        we;
    logic        byte_m;
    logic        mem_op;
    logic [15:0] rd_data;
    logic        ready;
    logic [2:0]  err;
    logic [1:0]  ch_en;
    logic [19:0] ch_addr;
    logic [15:0] ch_wr_data;
    logic        ch_we;
    logic        ch_byte_m;
    logic [31:0] ch_rd_data;
    logic [1:0]  ch_ready;

    int n_cmp = 0;
    int n_err = 0;

    mem_region_router #(
        .NCH        (2),
        .REGION_MAP ({16'h9800, 16'h6BFF}),
        .RO_MASK    (2'b10),
        .TIMEOUT    (8),
        .DEF_DATA   (16'hDEAD)
    ) dut (
        .cpu_clk    (cpu_clk),
        .reset      (reset),
        .addr       (addr),
        .wr_data    (wr_data),
        .we         (we),
        .byte_m     (byte_m),
        .mem_op     (mem_op),
        .rd_data    (rd_data),
        .ready      (ready),
        .err        (err),
        .ch_en      (ch_en),
        .ch_addr    (ch_addr),
        .ch_wr_data (ch_wr_data),
        .ch_we      (ch_we),
        .ch_byte_m  (ch_byte_m),
        .ch_rd_data (ch_rd_data),
        .ch_ready   (ch_ready)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic release_op(input string tag);
        ch_ready = '0;
        mem_op   = 1'b0;
        tick();
        check(tag, 32'(ready), 32'h0);
    endtask

    initial begin
        reset = 1'b1; addr = '0; wr_data = '0; we = 1'b0; byte_m = 1'b0;
        mem_op = 1'b0; ch_rd_data = '0; ch_ready = '0;
        tick(); tick();
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_en", 32'(ch_en), 32'h0);
        check("rst_rd", 32'(rd_data), 32'h0);
        check("rst_addr", 32'(ch_addr), 32'h0);
        check("rst_we", 32'(ch_we), 32'h0);
        reset = 1'b0;
        tick();

        // ch0 read with three wait cycles
        addr = 20'h01234; ch_rd_data = {16'h1234, 16'hBEEF}; mem_op = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check("t1_en", 32'(ch_en), 32'h1);
            check("t1_busy", 32'(ready), 32'h0);
        end
        ch_ready = 2'b01;
        tick();
        check("t1_ready", 32'(ready), 32'h1);
        check("t1_en_off", 32'(ch_en), 32'h0);
        check("t1_rd", 32'(rd_data), 32'hBEEF);
        check("t1_err", 32'(err), 32'h0);
        check("t1_addr", 32'(ch_addr), 32'h01234);
        ch_ready = '0;

        // mem_op held after completion
        for (int e = 0; e < 5; e++) begin
            tick();
            check("hold_ready", 32'(ready), 32'h1);
            check("hold_en", 32'(ch_en), 32'h0);
        end
        release_op("t1_drop");

        // ROM read on ch1, immediate ready, accepted right after the drop
        addr = 20'hF0010; ch_ready = 2'b10; mem_op = 1'b1;
        tick();
        check("t2_en", 32'(ch_en), 32'h2);
        tick();
        check("t2_ready", 32'(ready), 32'h1);
        check("t2_rd", 32'(rd_data), 32'h1234);
        release_op("t2_drop");

        // ch0 byte write leaves rd_data alone
        addr = 20'h05000; we = 1'b1; byte_m = 1'b1; wr_data = 16'hABCD; ch_ready = 2'b01; mem_op = 1'b1;
        tick();
        check("wr_en", 32'(ch_en), 32'h1);
        check("wr_data", 32'(ch_wr_data), 32'hABCD);
        check("wr_we", 32'(ch_we), 32'h1);
        check("wr_bm", 32'(ch_byte_m), 32'h1);
        tick();
        check("wr_ready", 32'(ready), 32'h1);
        check("wr_rd", 32'(rd_data), 32'h1234);
        check("wr_err", 32'(err), 32'h0);
        release_op("wr_drop");

        // unmapped nibble 0xA
        addr = 20'hA0000; we = 1'b0; byte_m = 1'b0; mem_op = 1'b1;
        tick();
        check("um_ready", 32'(ready), 32'h1);
        check("um_err", 32'(err), 32'h1);
        check("um_rd", 32'(rd_data), 32'hDEAD);
        check("um_en", 32'(ch_en), 32'h0);
        release_op("um_drop");

        // write to read-only ROM region
        addr = 20'hC0000; we = 1'b1; mem_op = 1'b1;
        tick();
        check("ro_ready", 32'(ready), 32'h1);
        check("ro_err", 32'(err), 32'h2);
        check("ro_en", 32'(ch_en), 32'h0);
        check("ro_rd", 32'(rd_data), 32'hDEAD);
        release_op("ro_drop");

        // nibble 0xB in both maps: ch0 wins, ch1 ready ignored
        addr = 20'hB0000; we = 1'b0; ch_rd_data = {16'h1111, 16'h5A5A}; ch_ready = 2'b10; mem_op = 1'b1;
        tick();
        check("pri_en", 32'(ch_en), 32'h1);
        tick();
        check("pri_ign", 32'(ready), 32'h0);
        check("pri_en2", 32'(ch_en), 32'h1);
        ch_ready = 2'b01;
        tick();
        check("pri_ready", 32'(ready), 32'h1);
        check("pri_rd", 32'(rd_data), 32'h5A5A);
        release_op("pri_drop");

        // reset during REQ, then a normal request
        addr = 20'h01000; mem_op = 1'b1;
        tick();
        check("rq_en", 32'(ch_en), 32'h1);
        reset = 1'b1;
        tick();
        check("rq_rst_en", 32'(ch_en), 32'h0);
        check("rq_rst_ready", 32'(ready), 32'h0);
        check("rq_rst_rd", 32'(rd_data), 32'h0);
        reset = 1'b0;
        addr = 20'hF0000; ch_rd_data = {16'h7777, 16'h0000}; ch_ready = 2'b10;
        tick();
        check("rec_en", 32'(ch_en), 32'h2);
        tick();
        check("rec_ready", 32'(ready), 32'h1);
        check("rec_rd", 32'(rd_data), 32'h7777);
        release_op("rec_drop");

        // timeout: ch_en for 8 cycles, ready at cycle 9
        addr = 20'h02000; mem_op = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check("tmo_en", 32'(ch_en), 32'h1);
            check("tmo_busy", 32'(ready), 32'h0);
        end
        tick();
        check("tmo_ready", 32'(ready), 32'h1);
        check("tmo_en_off", 32'(ch_en), 32'h0);
        check("tmo_err", 32'(err), 32'h4);
        check("tmo_rd", 32'(rd_data), 32'hDEAD);
        release_op("tmo_drop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
